// File: rtl/ctrl_seq_decoder_if.sv
// Fetch-side bus of the sequential control decoder.
//   instr_valid  fetch -> decoder  instruction word is present
//   instr        fetch -> decoder  instruction word
//   cmp_in       ALU   -> decoder  compare flags {zero, eq, gt}, sampled on CMP only
//   instr_ready  decoder -> fetch  decoder accepts the word (low only in HALT)
// The master modport is the fetch/ALU side; the slave modport is the decoder.
interface ctrl_seq_decoder_if #(
  parameter int unsigned INSTR_W = 9
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         cmp_in;
  logic               instr_ready;

  modport master (
    output instr_valid,
    output instr,
    output cmp_in,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  cmp_in,
    output instr_ready
  );
endinterface

// File: rtl/ctrl_seq_decoder.sv
// Sequential control decoder. Consumes instruction words over a valid/ready
// fetch handshake and drives datapath control: ALU op and operand select,
// acc/reg load strobes, data-memory write, LFSR strobes and PC branch load.
// Owns the multi-word state, the latched ALU op, the immediate accumulator
// and the compare flag register.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   io_fetch              fetch handshake + compare flags (slave modport)
//   o_state               REG=0 TARGET=1 IMM=2 SKIP=3 HALT=4
//   o_cmp_flags           registered {zero, eq, gt}
//   o_branch_en/target    PC load strobe and destination
//   o_memory_target       direct data-memory address
//   o_mem_addr_ctrl       1: o_memory_target, 0: mem reg as pointer
//   o_mem_value_ctrl      1: acc, 0: mem reg as write data
//   o_mem_wr_en           data-memory write strobe
//   o_opcode              ALU op: ADD=0 SUB=1 AND=2 OR=3 XOR=4 XORA=5
//   o_alu_input           B select: 00 mem, 01 target data, 10 imm, 11 LFSR
//   o_immediate           assembled immediate
//   o_acc/reg_load_ctrl   destination select; o_acc/reg_load_en write strobes
//   o_acc_clr, o_reg_clr, o_lfsr_set_state, o_lfsr_set_tap_ptrn, o_lfsr_shift
//   o_ack                 program done (HALT), level
// Word layout: [INSTR_W-1]=branch, [INSTR_W-2:INSTR_W-5]=op, [3:0]=sub.
module ctrl_seq_decoder #(
  parameter int unsigned INSTR_W   = 9,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PC_W      = 9,
  parameter int unsigned IMM_WORDS = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ctrl_seq_decoder_if.slave io_fetch,
  output logic [2:0]        o_state,
  output logic [2:0]        o_cmp_flags,
  output logic              o_branch_en,
  output logic [PC_W-1:0]   o_branch_target,
  output logic [PC_W-1:0]   o_memory_target,
  output logic              o_mem_addr_ctrl,
  output logic              o_mem_value_ctrl,
  output logic              o_mem_wr_en,
  output logic [2:0]        o_opcode,
  output logic [1:0]        o_alu_input,
  output logic [DATA_W-1:0] o_immediate,
  output logic              o_acc_load_ctrl,
  output logic              o_reg_load_ctrl,
  output logic              o_acc_load_en,
  output logic              o_reg_load_en,
  output logic              o_acc_clr,
  output logic              o_reg_clr,
  output logic              o_lfsr_set_state,
  output logic              o_lfsr_set_tap_ptrn,
  output logic              o_lfsr_shift,
  output logic              o_ack
);

  localparam int unsigned PAY_W = INSTR_W - 2;
  localparam int unsigned ACC_W = IMM_WORDS * PAY_W;
  localparam logic [1:0]  CntLast = 2'(IMM_WORDS - 1);

  localparam logic [2:0] StReg    = 3'd0;
  localparam logic [2:0] StTarget = 3'd1;
  localparam logic [2:0] StImm    = 3'd2;
  localparam logic [2:0] StSkip   = 3'd3;
  localparam logic [2:0] StHalt   = 3'd4;

  // What the TARGET word is used for.
  localparam logic [1:0] KindAlu    = 2'd0;
  localparam logic [1:0] KindBr     = 2'd1;
  localparam logic [1:0] KindStrAcc = 2'd2;
  localparam logic [1:0] KindStrReg = 2'd3;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpAnd  = 3'd2;
  localparam logic [2:0] OpOr   = 3'd3;
  localparam logic [2:0] OpXor  = 3'd4;
  localparam logic [2:0] OpXora = 3'd5;

  // Returns {valid, dest_is_reg, alu_opcode} for a 4-bit op field.
  function automatic logic [4:0] alu_dec(input logic [3:0] op);
    case (op)
      4'h1:    alu_dec = {2'b10, OpAdd};
      4'h2:    alu_dec = {2'b10, OpSub};
      4'h3:    alu_dec = {2'b11, OpAdd};
      4'h5:    alu_dec = {2'b10, OpAnd};
      4'h6:    alu_dec = {2'b10, OpOr};
      4'h7:    alu_dec = {2'b10, OpXor};
      4'h8:    alu_dec = {2'b10, OpXora};
      default: alu_dec = 5'b0;
    endcase
  endfunction

  logic [2:0]       r_state, w_state_nxt;
  logic [3:0]       r_op, w_op_nxt;
  logic [1:0]       r_kind, w_kind_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_shift;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [2:0]       r_cmp, w_cmp_nxt;

  logic [INSTR_W-1:0] w_word;
  logic               w_ready, w_fire, w_br, w_cond, w_exec;
  logic [3:0]         w_op, w_sub, w_exec_op;
  logic [4:0]         w_dec;

  assign w_word  = io_fetch.instr;
  assign w_ready = (r_state != StHalt);
  assign w_fire  = io_fetch.instr_valid & w_ready;
  assign w_br    = w_word[INSTR_W-1];
  assign w_op    = w_word[INSTR_W-2 -: 4];
  assign w_sub   = w_word[3:0];

  // Payload chunks arrive MSB first.
  assign w_acc_shift = (r_acc << PAY_W) | ACC_W'(w_word[PAY_W-1:0]);

  // Branch condition from registered flags {zero, eq, gt}.
  always_comb begin
    case (w_op[2:0])
      3'd0:    w_cond = 1'b1;
      3'd1:    w_cond = r_cmp[2];
      3'd2:    w_cond = r_cmp[0];
      3'd3:    w_cond = r_cmp[0] | r_cmp[1];
      3'd4:    w_cond = ~r_cmp[0] & ~r_cmp[1];
      3'd5:    w_cond = ~r_cmp[0];
      3'd6:    w_cond = r_cmp[1];
      default: w_cond = ~r_cmp[1];
    endcase
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_op_nxt            = r_op;
    w_kind_nxt          = r_kind;
    w_acc_nxt           = r_acc;
    w_cnt_nxt           = r_cnt;
    w_cmp_nxt           = r_cmp;
    w_exec              = 1'b0;
    w_exec_op           = w_op;
    o_branch_en         = 1'b0;
    o_mem_addr_ctrl     = 1'b0;
    o_mem_value_ctrl    = 1'b0;
    o_mem_wr_en         = 1'b0;
    o_opcode            = 3'b0;
    o_alu_input         = 2'b00;
    o_immediate         = '0;
    o_acc_load_ctrl     = 1'b0;
    o_reg_load_ctrl     = 1'b0;
    o_acc_load_en       = 1'b0;
    o_reg_load_en       = 1'b0;
    o_acc_clr           = 1'b0;
    o_reg_clr           = 1'b0;
    o_lfsr_set_state    = 1'b0;
    o_lfsr_set_tap_ptrn = 1'b0;
    o_lfsr_shift        = 1'b0;

    if (w_fire) begin
      case (r_state)
        StReg: begin
          if (w_br) begin
            if (w_op[3]) begin
              w_state_nxt = w_cond ? StTarget : StSkip;
              w_kind_nxt  = KindBr;
            end
          end else if (w_op == 4'h0) begin
            case (w_sub)
              4'h1: o_acc_clr           = 1'b1;
              4'h2: o_reg_clr           = 1'b1;
              4'h3: o_lfsr_set_state    = 1'b1;
              4'h4: o_lfsr_set_tap_ptrn = 1'b1;
              4'h5: o_lfsr_shift        = 1'b1;
              4'h8: w_cmp_nxt           = io_fetch.cmp_in;
              4'hC, 4'hD: begin
                w_state_nxt = StTarget;
                w_kind_nxt  = w_sub[0] ? KindStrReg : KindStrAcc;
              end
              4'hE: begin
                o_mem_wr_en      = 1'b1;
                o_mem_value_ctrl = 1'b1;
              end
              4'hF:    w_state_nxt = StHalt;
              default: ;
            endcase
          end else if (alu_dec(w_op) != 5'b0) begin
            case (w_sub[3:2])
              2'b00: w_exec = 1'b1;
              2'b11: begin
                w_exec      = 1'b1;
                o_alu_input = 2'b11;
              end
              2'b01: begin
                w_op_nxt    = w_op;
                w_kind_nxt  = KindAlu;
                w_state_nxt = StTarget;
              end
              default: begin
                w_op_nxt    = w_op;
                w_acc_nxt   = '0;
                w_cnt_nxt   = 2'd0;
                w_state_nxt = StImm;
              end
            endcase
          end
        end
        StTarget: begin
          w_state_nxt = StReg;
          case (r_kind)
            KindBr: o_branch_en = 1'b1;
            KindStrAcc, KindStrReg: begin
              o_mem_addr_ctrl  = 1'b1;
              o_mem_wr_en      = 1'b1;
              o_mem_value_ctrl = (r_kind == KindStrAcc);
            end
            default: begin
              o_mem_addr_ctrl = 1'b1;
              o_alu_input     = 2'b01;
              w_exec          = 1'b1;
              w_exec_op       = r_op;
            end
          endcase
        end
        StImm: begin
          w_acc_nxt = w_acc_shift;
          if (r_cnt == CntLast) begin
            o_immediate = DATA_W'(w_acc_shift);
            o_alu_input = 2'b10;
            w_exec      = 1'b1;
            w_exec_op   = r_op;
            w_state_nxt = StReg;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        StSkip:  w_state_nxt = StReg;
        default: ;
      endcase
    end

    w_dec = alu_dec(w_exec_op);
    if (w_exec && w_dec[4]) begin
      o_opcode = w_dec[2:0];
      if (w_dec[3]) begin
        o_reg_load_ctrl = 1'b1;
        o_reg_load_en   = 1'b1;
      end else begin
        o_acc_load_ctrl = 1'b1;
        o_acc_load_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StReg;
      r_op    <= 4'h0;
      r_kind  <= KindAlu;
      r_acc   <= '0;
      r_cnt   <= 2'd0;
      r_cmp   <= 3'b0;
    end else if (w_fire) begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_kind  <= w_kind_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmp   <= w_cmp_nxt;
    end
  end

  assign io_fetch.instr_ready = w_ready;
  assign o_state              = r_state;
  assign o_cmp_flags          = r_cmp;
  assign o_ack                = (r_state == StHalt);
  assign o_branch_target      = PC_W'(w_word);
  assign o_memory_target      = PC_W'(w_word);

endmodule
